ps2_key_decoder: RTL and testbench

Scan-code decoder between `PS2_driver` and `main_ctrl`. It turns the raw set-2 byte stream (`ps2_byte` / `ps2_state`) into whole key events with make/break and extended flags resolved. Events are buffered in a small FIFO with a valid/ready handshake, so `main_ctrl` can consume one command per event without tracking prefix bytes itself.

---
 rtl/ps2_key_decoder_if.sv | 11 +
 rtl/ps2_key_decoder.sv | 165 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_if.sv
// Key-event handshake between ps2_key_decoder (master) and its consumer (slave).
interface ps2_key_decoder_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_ready;

  modport master (output key_valid, key_code, key_ext, key_break, input key_ready);
  modport slave  (input key_valid, key_code, key_ext, key_break, output key_ready);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: resolves E0/F0/E1 prefixes into key events and queues them.
// Optional typematic-repeat suppression is enabled with `define KEY_REPEAT_FILTER_EN.
module ps2_key_decoder #(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 2500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               ps2_byte,
  input  logic                     ps2_state,
  ps2_key_decoder_if.master        key,
  output logic                     overflow,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << ADDR_W;

  state_t          state, state_n;
  logic [2:0]      skip_cnt, skip_n;
  logic [WD_W-1:0] wd_cnt;
  logic            ps2_state_d;
  logic            new_byte, wd_timeout;
  logic            ev_push, ev_ext, ev_brk, push;

  assign new_byte   = ps2_state & ~ps2_state_d;
  assign wd_timeout = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign busy       = (state != IDLE);

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      skip_cnt    <= '0;
      ps2_state_d <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state       <= state_n;
      skip_cnt    <= skip_n;
      ps2_state_d <= ps2_state;
      if (new_byte || state == IDLE || wd_timeout) wd_cnt <= '0;
      else                                         wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    skip_n  = skip_cnt;
    ev_push = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (new_byte) begin
      unique case (state)
        IDLE: begin
          unique case (ps2_byte)
            8'hE0: state_n = EXT;
            8'hF0: state_n = BRK;
            8'hE1: begin state_n = SKIP; skip_n = 3'd7; end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_n = IDLE;
            default: ev_push = 1'b1;
          endcase
        end
        EXT: begin
          if (ps2_byte == 8'hF0) state_n = EXT_BRK;
          else begin
            state_n = IDLE;
            ev_ext  = 1'b1;
            ev_push = !is_fake_shift(ps2_byte);
          end
        end
        BRK: begin
          state_n = IDLE;
          ev_brk  = 1'b1;
          ev_push = 1'b1;
        end
        EXT_BRK: begin
          state_n = IDLE;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
          ev_push = !is_fake_shift(ps2_byte);
        end
        SKIP: begin
          skip_n = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (wd_timeout) begin
      state_n = IDLE;
      skip_n  = '0;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic       held, held_ext, held_match;
  logic [7:0] held_code;

  assign held_match = held && (held_ext == ev_ext) && (held_code == ps2_byte);
  assign push       = ev_push && !(!ev_brk && held_match);

  always_ff @(posedge clk) begin
    if (rst) begin
      held      <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
    end else if (ev_push) begin
      if (!ev_brk) begin
        held      <= 1'b1;
        held_ext  <= ev_ext;
        held_code <= ps2_byte;
      end else if (held_match) begin
        held <= 1'b0;
      end
    end
  end
`else
  assign push = ev_push;
`endif

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [9:0]        mem [0:DEPTH-1];
  logic [9:0]        last_pop, head;
  logic              empty, full, pop, do_write;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign pop      = key.key_valid & key.key_ready;
  assign do_write = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_pop <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write)             wr_ptr   <= wr_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= {ev_ext, ev_brk, ps2_byte};
  end

  assign head          = empty ? last_pop : mem[rd_ptr[ADDR_W-1:0]];
  assign key.key_valid = ~empty;
  assign key.key_ext   = head[9];
  assign key.key_break = head[8];
  assign key.key_code  = head[7:0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized key actions
// scored against an event-level reference model.
module tb_ps2_key_decoder;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_byte = '0;
  logic       ps2_state = 1'b0;
  logic       overflow, busy;
  logic       auto_mon = 1'b0;
  logic       manual_ready = 1'b0;
  logic       rnd_timing = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] exp_q[$];
  logic       m_held = 1'b0;
  logic [8:0] m_key = '0;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_state(ps2_state),
    .key(bus), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer: random ready under scoreboard mode, forced high when the backlog grows.
  always @(posedge clk) begin
    #2;
    if (auto_mon) bus.key_ready = (exp_q.size() >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
    else          bus.key_ready = manual_ready;
  end

  always @(negedge clk) begin
    if (auto_mon && bus.key_valid && bus.key_ready) begin
      if (exp_q.size() == 0) check("spurious_event", 1, 0);
      else check("sb_event", {bus.key_ext, bus.key_break, bus.key_code}, exp_q.pop_front());
    end
  end

  // Reference: decides whether a resolved key action yields a queued event.
  function automatic logic model_push(input logic ext, input logic brk, input logic [7:0] code);
`ifdef KEY_REPEAT_FILTER_EN
    if (!brk) begin
      if (m_held && m_key == {ext, code}) return 1'b0;
      m_held = 1'b1;
      m_key  = {ext, code};
    end else if (m_held && m_key == {ext, code}) begin
      m_held = 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int hi, lo;
    hi = rnd_timing ? $urandom_range(1, 3) : 1;
    lo = rnd_timing ? $urandom_range(1, 3) : 1;
    @(posedge clk); #1;
    ps2_byte  = b;
    ps2_state = 1'b1;
    repeat (hi) @(posedge clk);
    #1 ps2_state = 1'b0;
    repeat (lo - 1) @(posedge clk);
  endtask

  task automatic send_event(input logic ext, input logic brk, input logic [7:0] code);
    if (ext) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    if (model_push(ext, brk, code)) exp_q.push_back({ext, brk, code});
    send_byte(code);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_held = 1'b0;
    exp_q.delete();
  endtask

  task automatic pop_check(input string tag, input logic [9:0] exp);
    @(posedge clk); #1 manual_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, bus.key_valid, 1);
    check(tag, {bus.key_ext, bus.key_break, bus.key_code}, exp);
    @(posedge clk); #1 manual_ready = 1'b0;
  endtask

  task automatic drain_wait(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.key_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, (n < 300) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pool [4];
    logic [7:0] junk [6];
    logic [7:0] pause_seq [8];
    logic [7:0] fill5 [5];
    logic [7:0] rep_seq [6];
    pool      = '{8'h1C, 8'h1D, 8'h75, 8'h6B};
    junk      = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    fill5     = '{8'h15, 8'h1C, 8'h32, 8'h21, 8'h23};
    rep_seq   = '{8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D, 8'h1D};

    do_reset();
    @(negedge clk);
    check("rst_valid", bus.key_valid, 0);
    check("rst_code", bus.key_code, 0);
    check("rst_ext", bus.key_ext, 0);
    check("rst_break", bus.key_break, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    // Single make: valid appears the cycle after the strobe.
    @(posedge clk); #1 ps2_byte = 8'h1D; ps2_state = 1'b1;
    @(negedge clk); check("lat_strobe_cycle", bus.key_valid, 0);
    @(negedge clk); check("lat_next_cycle", bus.key_valid, 1);
    #1 ps2_state = 1'b0;
    pop_check("make_1d", {2'b00, 8'h1D});
    @(negedge clk); check("make_1d_empty", bus.key_valid, 0);

    // Extended release with busy tracking.
    send_byte(8'hE0); @(negedge clk); check("busy_after_e0", busy, 1);
    send_byte(8'hF0); @(negedge clk); check("busy_after_f0", busy, 1);
    send_byte(8'h75); @(negedge clk); check("busy_after_75", busy, 0);
    pop_check("ext_brk_75", {2'b11, 8'h75});
    @(negedge clk); check("ext_brk_single", bus.key_valid, 0);

    // Pause produces nothing; the following make does.
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    @(negedge clk); check("pause_no_event", bus.key_valid, 0);
    send_byte(8'h1C);
    pop_check("after_pause", {2'b00, 8'h1C});
    @(negedge clk); check("after_pause_empty", bus.key_valid, 0);

    // Overflow: five makes into a four-deep queue.
    foreach (fill5[i]) send_byte(fill5[i]);
    @(negedge clk); check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_drain%0d", i), {2'b00, fill5[i]});
    @(negedge clk);
    check("ovf_drain_empty", bus.key_valid, 0);
    check("ovf_sticky", overflow, 1);
    do_reset();
    @(negedge clk); check("ovf_cleared", overflow, 0);

    // Full queue with simultaneous pop and push: nothing is lost.
    for (int i = 0; i < 4; i++) send_byte(fill5[i]);
    @(posedge clk); #1 ps2_byte = fill5[4]; ps2_state = 1'b1; manual_ready = 1'b1;
    @(posedge clk); #1 ps2_state = 1'b0; manual_ready = 1'b0;
    @(negedge clk); check("full_pushpop_ovf", overflow, 0);
    for (int i = 1; i < 5; i++) pop_check($sformatf("full_pushpop%0d", i), {2'b00, fill5[i]});
    @(negedge clk); check("full_pushpop_empty", bus.key_valid, 0);

    // Watchdog abandons a dangling E0.
    send_byte(8'hE0);
    @(negedge clk); check("wd_busy_start", busy, 1);
    repeat (TIMEOUT - 5) @(posedge clk);
    @(negedge clk); check("wd_busy_before", busy, 1);
    repeat (10) @(posedge clk);
    @(negedge clk); check("wd_busy_after", busy, 0);
    send_byte(8'h23);
    pop_check("wd_event", {2'b00, 8'h23});

    // Typematic repeat sequence through the scoreboard.
    do_reset();
    auto_mon = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rep_seq[i] == 8'hF0) continue;
      if (model_push(1'b0, (i > 0 && rep_seq[i-1] == 8'hF0), rep_seq[i]))
        exp_q.push_back({1'b0, (i > 0 && rep_seq[i-1] == 8'hF0), rep_seq[i]});
    end
`ifdef KEY_REPEAT_FILTER_EN
    check("rep_expected_count", exp_q.size(), 3);
`else
    check("rep_expected_count", exp_q.size(), 5);
`endif
    foreach (rep_seq[i]) send_byte(rep_seq[i]);
    drain_wait("rep");
    check("rep_no_overflow", overflow, 0);

    // Randomized key actions.
    do_reset();
    rnd_timing = 1'b1;
    for (int n = 0; n < 120; n++) begin
      int kind;
      logic [7:0] code;
      kind = $urandom_range(0, 6);
      code = pool[$urandom_range(0, 3)];
      case (kind)
        0: send_event(1'b0, 1'b0, code);
        1: send_event(1'b0, 1'b1, code);
        2: send_event(1'b1, 1'b0, code);
        3: send_event(1'b1, 1'b1, code);
        4: send_byte(junk[$urandom_range(0, 5)]);
        5: begin
          send_byte(8'hE0);
          if ($urandom_range(0, 1) == 0) send_byte(8'h12);
          else begin send_byte(8'hF0); send_byte(8'h59); end
        end
        default: foreach (pause_seq[i]) send_byte(pause_seq[i]);
      endcase
      @(negedge clk); check("rnd_idle_busy", busy, 0);
    end
    drain_wait("rnd");
    check("rnd_no_overflow", overflow, 0);
    auto_mon = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
